bg_line_reader: RTL and testbench

BG_LINE_READER -- requirements
Module: bg_line_reader

---
 rtl/bg_line_reader.sv | 102 ++++++++++
 tb/tb_bg_line_reader.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bg_line_reader.sv
// bg_line_reader: reads one scanline from a line buffer and streams it out with horizontal mosaic.
//   clk, rst_b (async, active-low)
//   line_start/mosaic_h : start a line, mosaic block size minus one (latched at start)
//   buf_rd_en/buf_rd_addr/buf_rd_data : line-buffer read port, data one cycle after strobe
//   pix_valid/pix_ready/pix_data/pix_x : pixel stream with valid/ready handshake
//   busy/line_done : line in progress, one-cycle pulse after last pixel accepted
module bg_line_reader #(
  parameter int LINE_W = 240,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              line_start,
  input  logic [3:0]        mosaic_h,
  output logic              buf_rd_en,
  output logic [7:0]        buf_rd_addr,
  input  logic [DATA_W-1:0] buf_rd_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [DATA_W-1:0] pix_data,
  output logic [7:0]        pix_x,
  output logic              busy,
  output logic              line_done
);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2;
  localparam logic [8:0] LAST = 9'(LINE_W - 1);
  logic [1:0]        state;
  logic [3:0]        m, rep;
  logic [8:0]        na, step;
  logic              inflight, wp, rp;
  logic [1:0]        cnt, cnt_n;
  logic [DATA_W-1:0] mem [2];
  logic              acc, fin, push, pop, last;
  assign busy = state != IDLE;
  // the word returning from the buffer is presented directly when the FIFO is empty
  assign pix_valid = busy && (cnt != 2'd0 || inflight);
  assign pix_data = cnt != 2'd0 ? mem[rp] : inflight ? buf_rd_data : '0;
  always_comb begin
    acc = pix_valid && pix_ready;
    last = {1'b0, pix_x} == LAST;
    fin = acc && (rep == m || last);
    push = inflight && !(cnt == 2'd0 && fin);
    pop = fin && cnt != 2'd0;
    cnt_n = cnt + {1'b0, push} - {1'b0, pop};
    step = na + {5'd0, m} + 9'd1;
  end
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state <= IDLE;
      m <= '0;
      rep <= '0;
      na <= '0;
      inflight <= 1'b0;
      cnt <= '0;
      wp <= 1'b0;
      rp <= 1'b0;
      mem[0] <= '0;
      mem[1] <= '0;
      buf_rd_en <= 1'b0;
      buf_rd_addr <= '0;
      pix_x <= '0;
      line_done <= 1'b0;
    end else begin
      line_done <= fin && last && state == DRAIN;
      if (line_start) begin
        // restart: drop FIFO contents and ignore the read still returning
        state <= ({5'd0, mosaic_h} + 9'd1 >= 9'(LINE_W)) ? DRAIN : RUN;
        m <= mosaic_h;
        rep <= '0;
        pix_x <= '0;
        cnt <= '0;
        wp <= 1'b0;
        rp <= 1'b0;
        inflight <= 1'b0;
        buf_rd_en <= 1'b1;
        buf_rd_addr <= '0;
        na <= {5'd0, mosaic_h} + 9'd1;
      end else begin
        inflight <= buf_rd_en;
        cnt <= cnt_n;
        if (push) begin
          mem[wp] <= buf_rd_data;
          wp <= ~wp;
        end
        if (pop) rp <= ~rp;
        if (acc) begin
          pix_x <= pix_x + 8'd1;
          rep <= fin ? 4'd0 : rep + 4'd1;
        end
        buf_rd_en <= 1'b0;
        // next-cycle occupancy plus the word then returning must leave room for this read
        if (state == RUN && cnt_n + {1'b0, buf_rd_en} < 2'd2) begin
          buf_rd_en <= 1'b1;
          buf_rd_addr <= na[7:0];
          na <= step;
          if (step >= 9'(LINE_W)) state <= DRAIN;
        end
        if (fin && last) state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_bg_line_reader.sv
// tb_bg_line_reader: directed checks of bg_line_reader against a line-buffer model.
module tb_bg_line_reader;
  localparam int LW = 240;
  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        line_start = 1'b0;
  logic [3:0]  mosaic_h = '0;
  logic        buf_rd_en;
  logic [7:0]  buf_rd_addr;
  logic [15:0] buf_rd_data = '0;
  logic        pix_valid;
  logic        pix_ready = 1'b0;
  logic [15:0] pix_data;
  logic [7:0]  pix_x;
  logic        busy;
  logic        line_done;
  int tests = 0;
  int fails = 0;
  logic [7:0] lid = '0;
  logic [3:0] tm = '0;
  int rd_count = 0;
  int rd_bad = 0;
  int next_exp = 0;

  bg_line_reader #(.LINE_W(LW), .DATA_W(16)) dut (
    .clk(clk), .rst_b(rst_b), .line_start(line_start), .mosaic_h(mosaic_h),
    .buf_rd_en(buf_rd_en), .buf_rd_addr(buf_rd_addr), .buf_rd_data(buf_rd_data),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data), .pix_x(pix_x),
    .busy(busy), .line_done(line_done)
  );

  always #5 clk = ~clk;

  // buffer word = {line id, address}; read addresses tracked against the expected block starts
  always @(posedge clk) begin
    if (buf_rd_en) buf_rd_data <= {lid, buf_rd_addr};
    if (line_start) begin
      lid <= lid + 8'd1;
      tm <= mosaic_h;
      rd_count <= 0;
      rd_bad <= 0;
      next_exp <= 0;
    end else if (buf_rd_en) begin
      if (int'(buf_rd_addr) != next_exp || next_exp >= LW) rd_bad <= rd_bad + 1;
      next_exp <= next_exp + int'(tm) + 1;
      rd_count <= rd_count + 1;
    end
  end

  task automatic start_line(input logic [3:0] m);
    mosaic_h = m;
    line_start = 1'b1;
    @(negedge clk);
    line_start = 1'b0;
  endtask

  task automatic run_line(input int m, input bit rnd);
    int got, cyc;
    logic stall;
    logic [7:0] px;
    logic [15:0] pd;
    logic [15:0] ed;
    got = 0;
    cyc = 0;
    stall = 1'b0;
    px = '0;
    pd = '0;
    while (got < LW && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      pix_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stall) begin
        tests++;
        if (pix_valid !== 1'b1 || pix_x !== px || pix_data !== pd) begin
          fails++;
          $display("FAIL stall_hold: v=%b x=%0d d=%h, expected v=1 x=%0d d=%h", pix_valid, pix_x, pix_data, px, pd);
        end
      end
      tests++;
      if (line_done !== 1'b0) begin
        fails++;
        $display("FAIL early_line_done: got %b at pixel %0d, expected 0", line_done, got);
      end
      if (pix_valid && pix_ready) begin
        ed = {lid, 8'(got - got % (m + 1))};
        tests++;
        if (pix_x !== 8'(got) || pix_data !== ed) begin
          fails++;
          $display("FAIL pixel: x=%0d d=%h, expected x=%0d d=%h", pix_x, pix_data, got, ed);
        end
        got++;
      end
      stall = pix_valid && !pix_ready;
      px = pix_x;
      pd = pix_data;
    end
    if (got < LW) begin
      tests++;
      fails++;
      $display("FAIL line_timeout: %0d pixels accepted, expected %0d", got, LW);
    end
    if (!rnd && m == 0) begin
      tests++;
      if (cyc != LW) begin
        fails++;
        $display("FAIL contiguous: %0d cycles, expected %0d", cyc, LW);
      end
    end
    @(negedge clk);
    tests++;
    if (line_done !== 1'b1 || busy !== 1'b0 || pix_valid !== 1'b0) begin
      fails++;
      $display("FAIL line_end: done=%b busy=%b v=%b, expected 1 0 0", line_done, busy, pix_valid);
    end
    tests++;
    if (rd_count != (LW + m) / (m + 1) || rd_bad != 0) begin
      fails++;
      $display("FAIL reads: count=%0d bad=%0d, expected count=%0d bad=0", rd_count, rd_bad, (LW + m) / (m + 1));
    end
    @(negedge clk);
    tests++;
    if (line_done !== 1'b0) begin
      fails++;
      $display("FAIL done_pulse: got %b, expected 0", line_done);
    end
  endtask

  task automatic test_reset();
    #2;
    tests++;
    if ({pix_valid, buf_rd_en, busy, line_done} !== 4'b0 || buf_rd_addr !== 8'd0 || pix_x !== 8'd0 || pix_data !== 16'd0) begin
      fails++;
      $display("FAIL reset_state: v=%b en=%b busy=%b done=%b addr=%0d x=%0d d=%h, expected all 0",
               pix_valid, buf_rd_en, busy, line_done, buf_rd_addr, pix_x, pix_data);
    end
    @(negedge clk);
    @(negedge clk);
    rst_b = 1'b1;
    repeat (5) begin
      @(negedge clk);
      tests++;
      if (busy !== 1'b0 || buf_rd_en !== 1'b0 || pix_valid !== 1'b0) begin
        fails++;
        $display("FAIL idle_after_reset: busy=%b en=%b v=%b, expected 0 0 0", busy, buf_rd_en, pix_valid);
      end
    end
  endtask

  task automatic test_m0();
    start_line(4'd0);
    tests++;
    if (busy !== 1'b1 || pix_valid !== 1'b0 || buf_rd_en !== 1'b1 || buf_rd_addr !== 8'd0) begin
      fails++;
      $display("FAIL first_cycle: busy=%b v=%b en=%b addr=%0d, expected 1 0 1 0", busy, pix_valid, buf_rd_en, buf_rd_addr);
    end
    run_line(0, 1'b0);
  endtask

  task automatic test_mosaic();
    start_line(4'd3);
    mosaic_h = 4'd9;
    run_line(3, 1'b0);
    start_line(4'd15);
    run_line(15, 1'b0);
  endtask

  task automatic test_random_ready();
    start_line(4'd0);
    run_line(0, 1'b1);
    start_line(4'd2);
    run_line(2, 1'b1);
  endtask

  task automatic test_abort();
    int cyc;
    start_line(4'd2);
    pix_ready = 1'b1;
    cyc = 0;
    while (!(pix_valid && pix_x == 8'd100) && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    tests++;
    if (pix_x !== 8'd100) begin
      fails++;
      $display("FAIL abort_reach: x=%0d, expected 100", pix_x);
    end
    start_line(4'd1);
    tests++;
    if (line_done !== 1'b0 || pix_valid !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL abort: done=%b v=%b busy=%b, expected 0 0 1", line_done, pix_valid, busy);
    end
    run_line(1, 1'b1);
  endtask

  task automatic test_back_to_back();
    int cyc;
    start_line(4'd0);
    pix_ready = 1'b1;
    cyc = 0;
    while (!(pix_valid && pix_x == 8'(LW - 1)) && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    start_line(4'd1);
    tests++;
    if (line_done !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL back_to_back: done=%b busy=%b, expected 1 1", line_done, busy);
    end
    run_line(1, 1'b0);
  endtask

  task automatic test_reset_mid();
    int cyc;
    start_line(4'd0);
    pix_ready = 1'b1;
    cyc = 0;
    while (!(pix_valid && pix_x == 8'd50) && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    #1 rst_b = 1'b0;
    #1;
    tests++;
    if ({pix_valid, buf_rd_en, busy, line_done} !== 4'b0 || buf_rd_addr !== 8'd0 || pix_x !== 8'd0 || pix_data !== 16'd0) begin
      fails++;
      $display("FAIL async_reset: v=%b en=%b busy=%b done=%b addr=%0d x=%0d d=%h, expected all 0",
               pix_valid, buf_rd_en, busy, line_done, buf_rd_addr, pix_x, pix_data);
    end
    @(negedge clk);
    rst_b = 1'b1;
    repeat (10) begin
      @(negedge clk);
      tests++;
      if (busy !== 1'b0 || buf_rd_en !== 1'b0 || pix_valid !== 1'b0 || line_done !== 1'b0) begin
        fails++;
        $display("FAIL post_reset_idle: busy=%b en=%b v=%b done=%b, expected 0 0 0 0", busy, buf_rd_en, pix_valid, line_done);
      end
    end
    start_line(4'd5);
    run_line(5, 1'b1);
  endtask

  initial begin
    test_reset();
    test_m0();
    test_mosaic();
    test_random_ready();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
